// File: rtl/rom_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl_pkg
//   Shared definitions for the ROM load controller slice: default bus
//   widths, ROM depth, checksum seed and the controller state encoding.
//   No ports.
// ---------------------------------------------------------------------------
package rom_load_ctrl_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int ROM_WORDS  = 64;
  localparam logic [31:0] CSUM_SEED = 32'h0;

  // VERIFY is always part of the encoding; it is simply never entered
  // unless the readback checksum feature is built in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl_if
//   Bundles the host load request, the host word stream, the system rom_*
//   port and the status outputs of the ROM load controller.
//   Modports:
//     master - the controller: consumes start/sel/base/len, in_valid/in_data
//              and rom_rd; drives in_ready, rom_*, cpu_hold, busy, done, error
//     slave  - host logic plus system (mirror image of master)
// ---------------------------------------------------------------------------
interface rom_load_ctrl_if
  import rom_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic              sel;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rom_we;
  logic              rom_select;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wd;
  logic [DATA_W-1:0] rom_rd;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, sel, base, len, in_valid, in_data, rom_rd,
    output in_ready, rom_we, rom_select, rom_addr, rom_wd,
           cpu_hold, busy, done, error
  );

  modport slave (
    output start, sel, base, len, in_valid, in_data, rom_rd,
    input  in_ready, rom_we, rom_select, rom_addr, rom_wd,
           cpu_hold, busy, done, error
  );

endinterface

// File: rtl/rom_load_ctrl_csum.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl_csum
//   Running rotate-left-by-one / XOR checksum register.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     clear_i     - reload the seed (wins over en_i)
//     en_i        - fold data_i into the checksum
//     data_i      - word to fold in
//     csum_o      - registered checksum
//     csum_d_o    - value the register takes at the next edge
// ---------------------------------------------------------------------------
module rom_load_ctrl_csum
  import rom_load_ctrl_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] csum_o,
  output logic [W-1:0] csum_d_o
);

  logic [W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear_i) begin
      csum_d = W'(CSUM_SEED);
    end else if (en_i) begin
      csum_d = {csum_q[W-2:0], csum_q[W-1]} ^ data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= W'(CSUM_SEED);
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o   = csum_q;
  assign csum_d_o = csum_d;

endmodule

// File: rtl/rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl
//   Host-side sequencer that streams program words into PMEM or EMEM through
//   the system rom_* port, holding the CPU in reset while a load runs and
//   reporting busy/done/error to the host test controller.
//   Ports:
//     sys_clk   - system clock, rising edge
//     sys_rst_n - synchronous active-low reset
//     bus       - rom_load_ctrl_if.master (request, word stream, rom_*,
//                 cpu_hold/busy/done/error)
//   Build option: define ROM_VERIFY_EN to add a readback VERIFY phase that
//   compares a checksum of the written words against the ROM contents.
// ---------------------------------------------------------------------------
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  rom_load_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              error_q, error_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rom_wd_q, rom_wd_d;

  logic inReady;
  logic handshake;
  logic lenBad;

  // Lengths above the ROM depth have bit ADDR_W set plus some lower bit.
  assign lenBad    = bus.len[ADDR_W] && (|bus.len[ADDR_W-1:0]);
  assign inReady   = (state_q == ST_WRITE) && (cnt_q < len_q);
  assign handshake = inReady && bus.in_valid;

`ifdef ROM_VERIFY_EN
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic              addrValid_q, addrValid_d;
  logic              rdValid_q, rdValid_d;
  logic              csumClear, csumEn;
  logic [DATA_W-1:0] csumData, csumQ, csumNext;

  rom_load_ctrl_csum #(.W(DATA_W)) u_csum (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clear_i (csumClear),
    .en_i    (csumEn),
    .data_i  (csumData),
    .csum_o  (csumQ),
    .csum_d_o(csumNext)
  );
`endif

  // Next-state logic. Writes are registered: a handshake in one cycle shows
  // up on rom_we/rom_addr/rom_wd in the next. WRITE only leaves once every
  // word is accepted, so the last write has already issued by then.
  // In VERIFY, addrValid marks a read address on the port this cycle and
  // rdValid marks that rom_rd carries the word for last cycle's address.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    error_d    = error_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_wd_d   = rom_wd_q;
`ifdef ROM_VERIFY_EN
    wsum_d      = wsum_q;
    addrValid_d = 1'b0;
    rdValid_d   = 1'b0;
    csumClear   = 1'b0;
    csumEn      = 1'b0;
    csumData    = bus.in_data;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_d   = bus.sel;
          base_d  = bus.base;
          len_d   = bus.len;
          cnt_d   = '0;
          error_d = 1'b0;
`ifdef ROM_VERIFY_EN
          csumClear = 1'b1;
`endif
          if (lenBad) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else if (bus.len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (handshake) begin
          rom_we_d   = 1'b1;
          rom_addr_d = base_q + cnt_q[ADDR_W-1:0];
          rom_wd_d   = bus.in_data;
          cnt_d      = cnt_q + 1'b1;
`ifdef ROM_VERIFY_EN
          csumEn = 1'b1;
`endif
        end else if (cnt_q == len_q) begin
`ifdef ROM_VERIFY_EN
          wsum_d      = csumQ;
          csumClear   = 1'b1;
          rom_addr_d  = base_q;
          cnt_d       = {{ADDR_W{1'b0}}, 1'b1};
          addrValid_d = 1'b1;
          state_d     = ST_VERIFY;
`else
          state_d = ST_DONE;
`endif
        end
      end

`ifdef ROM_VERIFY_EN
      ST_VERIFY: begin
        csumData  = bus.rom_rd;
        csumEn    = rdValid_q;
        rdValid_d = addrValid_q;
        if (addrValid_q && (cnt_q < len_q)) begin
          rom_addr_d  = base_q + cnt_q[ADDR_W-1:0];
          cnt_d       = cnt_q + 1'b1;
          addrValid_d = 1'b1;
        end
        // Last read word arrives this cycle; compare the folded-in value.
        if (rdValid_q && !addrValid_q) begin
          state_d = ST_DONE;
          if (csumNext != wsum_q) begin
            error_d = 1'b1;
          end
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_wd_q   <= rom_wd_d;
    end
  end

`ifdef ROM_VERIFY_EN
  // Readback bookkeeping registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wsum_q      <= '0;
      addrValid_q <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      wsum_q      <= wsum_d;
      addrValid_q <= addrValid_d;
      rdValid_q   <= rdValid_d;
    end
  end
`endif

  // rom_select follows the latched target and keeps it through IDLE.
  assign bus.in_ready   = inReady;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_select = sel_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_wd     = rom_wd_q;
  assign bus.cpu_hold   = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.error      = error_q;

endmodule
